// File: rtl/aes_key_expand.sv
// Iterative AES-128/192/256 key schedule: one 32-bit schedule word per clock,
// full round-key array held with a valid level until the next start.
// Optional feature macro: AES_KEY_EXPAND_ZEROIZE_EN (adds synchronous zeroize input).
module aes_key_expand #(
  parameter int unsigned Nk = 4,
  parameter int unsigned Nr = Nk + 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [32*Nk-1:0]  key,
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
  input  logic              zeroize,
`endif
  output logic [127:0]      k_sch [0:Nr],
  output logic              busy,
  output logic              done,
  output logic              valid
);

  localparam int unsigned NW = 4 * (Nr + 1);
  localparam int unsigned IW = 6;
  localparam int unsigned JW = 3;

  // Reject unsupported key sizes at elaboration
  if (!((Nk == 4) || (Nk == 6) || (Nk == 8)) || (Nr != Nk + 6)) begin : g_bad_param
    $error("aes_key_expand: Nk must be 4, 6 or 8 and Nr must equal Nk+6");
  end

  typedef enum logic {ST_IDLE, ST_EXPAND} state_t;

  state_t          state;
  logic [31:0]     w [NW];
  logic [IW-1:0]   idx;
  logic [JW-1:0]   j;      // idx mod Nk, tracked incrementally
  logic [7:0]      rcon;

  logic [31:0]     t_c;
  logic [31:0]     sub_in_c;
  logic [31:0]     temp_c;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // AES S-box: multiplicative inverse (x^254, maps 0 to 0) then affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 0; k < 7; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
  endfunction

  // Schedule recurrence: temp derived from w[i-1]
  always_comb begin
    t_c      = w[idx - IW'(1)];
    sub_in_c = (j == '0) ? {t_c[23:0], t_c[31:24]} : t_c;
    temp_c   = t_c;
    if (j == '0) begin
      temp_c = sub_word(sub_in_c) ^ {rcon, 24'h000000};
    end else if ((Nk == 8) && (j == JW'(4))) begin
      temp_c = sub_word(sub_in_c);
    end
  end

  // Control FSM and schedule word storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      for (int k = 0; k < NW; k++) w[k] <= '0;
      idx   <= '0;
      j     <= '0;
      rcon  <= 8'h01;
      busy  <= 1'b0;
      done  <= 1'b0;
      valid <= 1'b0;
    end else begin
      done <= 1'b0;
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
      if (zeroize) begin
        state <= ST_IDLE;
        for (int k = 0; k < NW; k++) w[k] <= '0;
        idx   <= '0;
        j     <= '0;
        rcon  <= 8'h01;
        busy  <= 1'b0;
        valid <= 1'b0;
      end else
`endif
      begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              for (int k = 0; k < Nk; k++) w[k] <= key[32*(Nk-k)-1 -: 32];
              idx   <= IW'(Nk);
              j     <= '0;
              rcon  <= 8'h01;
              valid <= 1'b0;
              busy  <= 1'b1;
              state <= ST_EXPAND;
            end
          end
          ST_EXPAND: begin
            w[idx] <= w[idx - IW'(Nk)] ^ temp_c;
            if (j == '0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            j <= (j == JW'(Nk - 1)) ? '0 : j + JW'(1);
            if (idx == IW'(NW - 1)) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              valid <= 1'b1;
            end else begin
              idx <= idx + IW'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Round key r is words 4r..4r+3, first word in the MSBs
  for (genvar r = 0; r <= Nr; r++) begin : g_ksch
    assign k_sch[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed checks of aes_key_expand for AES-128/192/256 against FIPS-197 vectors.
module tb_aes_key_expand;

  logic clk;
  logic rst_n;
  logic start4, start6, start8;
  logic [127:0] key4;
  logic [191:0] key6;
  logic [255:0] key8;
  logic zeroize;
  logic [127:0] k4 [0:10];
  logic [127:0] k6 [0:12];
  logic [127:0] k8 [0:14];
  logic busy4, done4, valid4;
  logic busy6, done6, valid6;
  logic busy8, done8, valid8;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] KEY_B   = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] KEY_C   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] A_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] B_RK12  = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] C_RK0   = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] C_RK14  = 128'hfe4890d1e6188d0b046df344706c631e;
  localparam logic [127:0] Z_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_expand #(.Nk(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .key(key4),
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .k_sch(k4), .busy(busy4), .done(done4), .valid(valid4)
  );

  aes_key_expand #(.Nk(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .start(start6), .key(key6),
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .k_sch(k6), .busy(busy6), .done(done6), .valid(valid6)
  );

  aes_key_expand #(.Nk(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .key(key8),
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .k_sch(k8), .busy(busy8), .done(done8), .valid(valid8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic get_done(input int sel);
    case (sel)
      0:       return done4;
      1:       return done6;
      default: return done8;
    endcase
  endfunction

  // Pulse start for one edge; returns at the negedge after the accepting edge
  task automatic start_dut(input int sel);
    case (sel)
      0:       start4 = 1'b1;
      1:       start6 = 1'b1;
      default: start8 = 1'b1;
    endcase
    @(negedge clk);
    start4 = 1'b0;
    start6 = 1'b0;
    start8 = 1'b0;
  endtask

  // Counts negedges until done is seen (bounded)
  task automatic wait_done(input int sel, output int n);
    n = 0;
    while (!get_done(sel) && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    int n2;
    rst_n   = 1'b0;
    start4  = 1'b0;
    start6  = 1'b0;
    start8  = 1'b0;
    zeroize = 1'b0;
    key4    = KEY_A;
    key6    = KEY_B;
    key8    = KEY_C;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy",  128'(busy4),  128'd0);
    check("rst_done",  128'(done4),  128'd0);
    check("rst_valid", 128'(valid4), 128'd0);
    check("rst_k0",    k4[0],        128'd0);
    check("rst_k10",   k4[10],       128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // AES-128
    start_dut(0);
    check("a_busy", 128'(busy4), 128'd1);
    wait_done(0, n);
    check("a_cycles", 128'(n), 128'd40);
    check("a_valid",  128'(valid4), 128'd1);
    check("a_busy_end", 128'(busy4), 128'd0);
    check("a_rk1",    k4[1],  A_RK1);
    check("a_rk10",   k4[10], A_RK10);
    @(negedge clk);
    check("a_done_pulse", 128'(done4), 128'd0);
    check("a_valid_hold", 128'(valid4), 128'd1);

    // AES-192
    start_dut(1);
    wait_done(1, n);
    check("b_cycles", 128'(n), 128'd46);
    check("b_valid",  128'(valid6), 128'd1);
    check("b_rk12",   k6[12], B_RK12);

    // AES-256
    start_dut(2);
    wait_done(2, n);
    check("c_cycles", 128'(n), 128'd52);
    check("c_rk0",    k8[0],  C_RK0);
    check("c_rk14",   k8[14], C_RK14);

    // start and key changes while busy are ignored
    @(negedge clk);
    key4 = KEY_A;
    start_dut(0);
    repeat (9) @(negedge clk);
    start4 = 1'b1;
    key4   = '0;
    @(negedge clk);
    start4 = 1'b0;
    wait_done(0, n2);
    check("ign_cycles", 128'(10 + n2), 128'd40);
    check("ign_rk1",  k4[1],  A_RK1);
    check("ign_rk10", k4[10], A_RK10);

    // start in the done cycle is accepted
    start_dut(0);
    check("re_valid", 128'(valid4), 128'd0);
    check("re_busy",  128'(busy4),  128'd1);
    check("re_done",  128'(done4),  128'd0);
    wait_done(0, n);
    check("re_cycles", 128'(n), 128'd40);
    check("re_rk10",   k4[10], Z_RK10);

    // Reset mid-expansion
    @(negedge clk);
    key4 = KEY_A;
    start_dut(0);
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mr_busy",  128'(busy4),  128'd0);
    check("mr_valid", 128'(valid4), 128'd0);
    check("mr_k0",    k4[0],  128'd0);
    check("mr_k10",   k4[10], 128'd0);
    @(negedge clk);
    check("mr_done", 128'(done4), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mr_nodone", 128'(done4), 128'd0);
    start_dut(0);
    wait_done(0, n);
    check("mr_cycles", 128'(n), 128'd40);
    check("mr_rk10",   k4[10], A_RK10);

`ifdef AES_KEY_EXPAND_ZEROIZE_EN
    // Zeroize clears a valid schedule
    @(negedge clk);
    zeroize = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    check("z_valid", 128'(valid4), 128'd0);
    check("z_k1",    k4[1],  128'd0);
    check("z_k10",   k4[10], 128'd0);
    // Zeroize beats start
    zeroize = 1'b1;
    start4  = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    start4  = 1'b0;
    check("zs_busy", 128'(busy4), 128'd0);
    @(negedge clk);
    check("zs_busy2", 128'(busy4), 128'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Iterative AES key schedule (FIPS-197 KeyExpansion) for AES-128/192/256.
- Sits directly upstream of the pipelined AES cipher core and drives its round-key array input.
- On a start pulse it latches the cipher key and computes one 32-bit schedule word per clock.
- The complete round-key array is held stable with a valid level until the next start.

Parameters:
- Nk, 4, key length in 32-bit words; legal values 4, 6, 8. Any other value is an elaboration error.
- Nr, Nk+6, number of rounds; must equal Nk+6.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin expansion; sampled only in IDLE.
- key  input  32*Nk  cipher key; the MSB word is w[0]; byte [31:24] of each word is its first byte.
- k_sch  output  128 x (Nr+1)  round keys, array indexed [0:Nr]; k_sch[r] = {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
- busy  output  1  high while in EXPAND.
- done  output  1  one-cycle pulse when the schedule completes.
- valid  output  1  level; k_sch holds the full schedule for the last accepted key.

Behaviour:
- Reset (async, active-low): state=IDLE; all words of k_sch=0; busy=0, done=0, valid=0; word index=0; rcon=8'h01.
- Total words: W = 4(Nr+1), giving 44, 52 or 60.
- States: IDLE and EXPAND.
- IDLE with start=1 at clock edge T:
  - Write w[0..Nk-1] from key.
  - Set index i=Nk, rcon=8'h01, valid=0.
  - Go to EXPAND; busy=1 after edge T.
- EXPAND: each edge writes w[i] = w[i-Nk] ^ temp, then i is incremented. temp is derived from t = w[i-1]:
  - i mod Nk == 0: temp = SubWord(RotWord(t)) ^ {rcon, 24'h0}; RotWord(t) = {t[23:0], t[31:24]}. After use, rcon <= xtime(rcon), so the sequence is 01,02,04,08,10,20,40,80,1b,36.
  - Nk==8 and i mod 8 == 4: temp = SubWord(t).
  - Otherwise: temp = t.
- SubWord applies the standard AES S-box to each of the 4 bytes.
- Completion:
  - w[W-1] is written at edge T+W-Nk, i.e. T+40, T+46 or T+52.
  - At that same edge: state=IDLE, busy=0, done=1 for exactly one cycle, valid=1.
- start while busy: ignored, with no effect on the key, index or outputs.
- start in the cycle that done=1: accepted (state is IDLE). valid drops after that edge.
- key is sampled only at the accepting edge; changes to key during EXPAND have no effect.
- While valid=0, k_sch contents are unspecified-but-deterministic: a partial mix of old and new words. The consumer must not load the cipher until valid=1.
- Reset mid-expansion: immediate return to reset values; no done pulse.
- k_sch is fully registered; no combinational path from any input to any output.

Optional Feature:
- Macro: AES_KEY_EXPAND_ZEROIZE_EN.
- With the macro defined: adds input port zeroize (1 bit).
  - zeroize=1 at an edge forces all k_sch words to 0 and sets valid=0, done=0, busy=0, state=IDLE, i=0, rcon=8'h01. This takes effect from any state.
  - zeroize has priority over start in the same cycle.
  - It is synchronous and single-cycle, and needs no reset.
- Without the macro: no zeroize port and no clearing logic. Key material persists until overwritten or reset.

Test Plan:
- Nk=4, key=2b7e151628aed2a6abf7158809cf4f3c, start pulsed at edge T:
  - busy=1 for 40 cycles; done pulses once after edge T+40, with valid=1 from then on.
  - k_sch[1]=a0fafe1788542cb123a339392a6c7605.
  - k_sch[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Nk=6, key=8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - done after 46 cycles.
  - k_sch[12]=e98ba06f448c773c8ecc720401002202.
- Nk=8, key=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - done after 52 cycles; k_sch[0] equals key[255:128].
  - k_sch[14]=fe4890d1e6188d0b046df344706c631e, which checks the i mod 8 == 4 SubWord path.
- Nk=4: start asserted again and key changed to all-zero at cycle 10 of an expansion:
  - Both are ignored; the result equals the first vector.
  - Then start in the done cycle with key=0: valid drops and the new result gives k_sch[10]=b4ef5bcb3e92e21123e951cf6f8f188e.
- Reset asserted at cycle 20 of an expansion: all k_sch words=0, busy=0, valid=0 immediately, and no done pulse. A start after release completes normally.
- With AES_KEY_EXPAND_ZEROIZE_EN:
  - zeroize=1 with valid=1: the next cycle shows k_sch all 0 and valid=0.
  - zeroize=1 together with start in IDLE: start is ignored and busy stays 0.
